// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared fetch-stage types and constants
package if_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - redirect, instruction-memory and IF_ID signals of the fetch queue
interface if_fetch_queue_if;
    logic        Redirect;
    logic [31:0] Target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        Instr_valid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic        Instr_ready;

    modport master (
        input  Redirect, Target, imem_gnt, imem_rvalid, imem_rdata, Instr_ready,
        output imem_req, imem_addr, Instr_valid, Instr, PC
    );

    modport slave (
        output Redirect, Target, imem_gnt, imem_rvalid, imem_rdata, Instr_ready,
        input  imem_req, imem_addr, Instr_valid, Instr, PC
    );
endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// rtl/if_fetch_queue_fetch_fifo.sv - DEPTH x {pc, instr} queue with flush and occupancy count
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  wdata_i,
    output fetch_entry_t  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - single-outstanding instruction fetcher feeding a small queue; FETCH_BYPASS_EN adds same-cycle bypass
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic              CLK,
    input logic              Reset,
    if_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic          drop_q, drop_d;

    fetch_entry_t  head, push_entry;
    logic [CW-1:0] count;
    logic [CW:0]   occ_next;
    logic          full, empty;
    logic          grant, resp_ok, bypass, push, pop;

    assign grant   = bus.imem_req && bus.imem_gnt;
    assign resp_ok = (state_q == ST_WAIT) && bus.imem_rvalid && !drop_q && !bus.Redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = empty && resp_ok;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed directly by IF_ID never occupies a slot.
    assign push       = resp_ok && !(bypass && bus.Instr_ready);
    assign pop        = !empty && bus.Instr_ready && !bus.Redirect;
    assign push_entry = '{pc: rpc_q, instr: bus.imem_rdata};
    assign occ_next   = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.Redirect),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        rpc_d   = rpc_q;
        drop_d  = drop_q;
        if (grant) begin
            fpc_d = fpc_q + 32'd4;
            rpc_d = fpc_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.Redirect || !full) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (grant) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = (bus.Redirect || occ_next < DEPTH_W) ? ST_REQ : ST_IDLE;
                end else if (bus.Redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A redirect racing its own grant leaves a stale word in flight.
        if (bus.Redirect) begin
            fpc_d = bus.Target & 32'hFFFF_FFFC;
            if (state_q == ST_REQ && grant) drop_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.imem_req    = !Reset && (state_q == ST_REQ) && !full;
    assign bus.imem_addr   = fpc_q;
    assign bus.Instr_valid = !Reset && (!empty || bypass);
    assign bus.Instr       = Reset ? '0 : (!empty ? head.instr : (bypass ? bus.imem_rdata : '0));
    assign bus.PC          = Reset ? '0 : (!empty ? head.pc    : (bypass ? rpc_q          : '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - vector-table and directed-sequence bench for if_fetch_queue
module tb_if_fetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if bus();

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst, redir;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy, chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] I0 = 32'h0010_0093;
    localparam logic [31:0] DD = 32'hDEAD_BEEF;

    initial begin
        bus.Redirect = 0; bus.Target = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0;
        bus.imem_rdata = 0; bus.Instr_ready = 0;

        //                rst redir tgt           gnt rv rdata          rdy chk req addr          val pc            instr
        vt.push_back(vec_t'{1, 0, 0,              0, 0, 0,             0, 0, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{1, 0, 0,              0, 0, 0,             0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h0,        0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 0, 0,            0, 0,            0});
`ifdef FETCH_BYPASS_EN
        vt.push_back(vec_t'{0, 0, 0,              0, 1, I0,            1, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 1, 32'h4,        0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h4,        0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'h55,        0, 1, 0, 0,            1, 32'h4,        32'h55});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 1, 32'h8,        1, 32'h4,        32'h55});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 1, 32'h8,        0, 0,            0});
`else
        vt.push_back(vec_t'{0, 0, 0,              0, 1, I0,            0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h4,        1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'hA1,        0, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h8,        1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'hA2,        0, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'hC,        1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'hA3,        0, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 0, 0,            1, 32'h0,        I0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 0, 0,            1, 32'h4,        32'hA1});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 1, 32'h10,       1, 32'h8,        32'hA2});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             1, 1, 1, 32'h10,       1, 32'hC,        32'hA3});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             1, 1, 1, 32'h10,       0, 0,            0});
        vt.push_back(vec_t'{0, 1, 32'h102,        0, 0, 0,             1, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, DD,            1, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h100,      0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'hB0,        0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h104,      1, 32'h100,      32'hB0});
        vt.push_back(vec_t'{0, 1, 32'h200,        0, 1, DD,            0, 1, 0, 0,            1, 32'h100,      32'hB0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 1, 32'h200,      0, 0,            0});
        vt.push_back(vec_t'{0, 1, 32'h303,        0, 0, 0,             0, 1, 1, 32'h200,      0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h300,      0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'hC0,        0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h304,      1, 32'h300,      32'hC0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'hC1,        0, 1, 0, 0,            1, 32'h300,      32'hC0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'h308,      1, 32'h300,      32'hC0});
        vt.push_back(vec_t'{1, 0, 0,              0, 0, 0,             0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 1, 32'h0,        0, 0,            0});
        vt.push_back(vec_t'{0, 1, 32'hFFFF_FFFF,  0, 0, 0,             0, 0, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              1, 0, 0,             0, 1, 1, 32'hFFFF_FFFC, 0, 0,           0});
        vt.push_back(vec_t'{0, 0, 0,              0, 1, 32'h13,        0, 1, 0, 0,            0, 0,            0});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'h13});
        vt.push_back(vec_t'{0, 1, 32'h40,         0, 0, 0,             1, 1, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'h13});
        vt.push_back(vec_t'{0, 0, 0,              0, 0, 0,             0, 1, 1, 32'h40,       0, 0,            0});
`endif

        foreach (vt[i]) begin
            @(negedge clk);
            rst             = vt[i].rst;
            bus.Redirect    = vt[i].redir;
            bus.Target      = vt[i].tgt;
            bus.imem_gnt    = vt[i].gnt;
            bus.imem_rvalid = vt[i].rv;
            bus.imem_rdata  = vt[i].rdata;
            bus.Instr_ready = vt[i].rdy;
            #2;
            if (vt[i].chk) begin
                check($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(vt[i].e_req));
                if (vt[i].e_req)
                    check($sformatf("v%0d imem_addr", i), bus.imem_addr, vt[i].e_addr);
                check($sformatf("v%0d Instr_valid", i), 32'(bus.Instr_valid), 32'(vt[i].e_val));
                if (vt[i].e_val || vt[i].rst) begin
                    check($sformatf("v%0d PC", i), bus.PC, vt[i].e_pc);
                    check($sformatf("v%0d Instr", i), bus.Instr, vt[i].e_instr);
                end
            end
        end

        // Redirect from wherever the table left off, then a bounded fetch of the target.
        begin
            int  n;
            logic found;
            @(negedge clk);
            bus.Redirect = 1; bus.Target = 32'h40; bus.imem_gnt = 0;
            bus.imem_rvalid = 0; bus.Instr_ready = 0;
            @(negedge clk);
            bus.Redirect = 0;
            n = 0;
            #1;
            while (!bus.imem_req && n < 8) begin
                @(negedge clk); #1;
                n++;
            end
            check("seq req_seen", 32'(bus.imem_req), 32'd1);
            check("seq req_addr", bus.imem_addr, 32'h40);
            bus.imem_gnt = 1;
            @(negedge clk);
            bus.imem_gnt    = 0;
            bus.imem_rvalid = 1;
            bus.imem_rdata  = 32'h0BAD_C0DE;
            found = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                #1;
                if (bus.Instr_valid) found = 1;
                else begin
                    @(negedge clk);
                    bus.imem_rvalid = 0;
                end
            end
            check("seq valid_seen", 32'(found), 32'd1);
            check("seq pc", bus.PC, 32'h40);
            check("seq instr", bus.Instr, 32'h0BAD_C0DE);
            @(negedge clk);
            bus.imem_rvalid = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port CLK, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port Redirect, input, width 1: taken branch or jump from the M stage.
REQ-006 SHALL have port Target, input, width 32: redirect address, sampled when Redirect=1.
REQ-007 SHALL have port imem_req, output, width 1: fetch request valid.
REQ-008 SHALL have port imem_addr, output, width 32: fetch address, word-aligned.
REQ-009 SHALL have port imem_gnt, input, width 1: request accepted this cycle.
REQ-010 SHALL have port imem_rvalid, input, width 1: response valid, at least 1 cycle after the grant.
REQ-011 SHALL have port imem_rdata, input, width 32: instruction word.
REQ-012 SHALL have port Instr_valid, output, width 1: queue head valid toward IF_ID.
REQ-013 SHALL have port Instr, output, width 32: head instruction.
REQ-014 SHALL have port PC, output, width 32: address of the head instruction.
REQ-015 SHALL have port Instr_ready, input, width 1: IF_ID accepts the head (pop when Instr_valid and Instr_ready are both 1).

Function
REQ-016 SHALL keep a fetch PC (fpc); each accepted request (imem_req and imem_gnt both 1) advances fpc by 4.
REQ-017 SHALL allow at most one outstanding request; FSM states: IDLE (no request), REQ (imem_req=1, waiting for grant), WAIT (granted, waiting for rvalid).
REQ-018 SHALL go IDLE->REQ when occupancy + outstanding < DEPTH; REQ->WAIT on grant; WAIT->REQ on rvalid if credit remains, otherwise WAIT->IDLE.
REQ-019 SHALL hold imem_addr stable while in REQ, except on a redirect.
REQ-020 SHALL push {fpc_of_request, imem_rdata} into the queue on each imem_rvalid that is not discarded.
REQ-021 SHALL drive Instr, PC and Instr_valid from the queue head, with registered storage.
REQ-022 SHALL have a minimum latency of 1 cycle from rvalid to Instr_valid=1 when built without the bypass feature.
REQ-023 SHALL, on Redirect=1, flush the queue and set fpc=Target with Target[1:0] forced to 00.
REQ-024 SHALL, on Redirect=1 in REQ, present Target on imem_addr the next cycle.
REQ-025 SHALL, on Redirect=1 in WAIT, set a drop flag so the in-flight response is discarded; the request for Target issues after that response returns.
REQ-026 SHALL discard a response that arrives in the same cycle as Redirect.
REQ-027 SHALL give Redirect priority over a same-cycle push or pop.
REQ-028 SHALL, when full, deassert imem_req.
REQ-029 SHALL, when empty, hold Instr_valid=0.
REQ-030 SHALL allow simultaneous push and pop without changing occupancy.
REQ-031 SHALL let the read and write pointers wrap modulo DEPTH.
REQ-032 SHALL let fpc wrap from 32'hFFFF_FFFC to 0.

Reset
REQ-033 SHALL, while Reset=1, set fpc=RESET_PC, clear the queue and the drop flag, set state=IDLE, and drive imem_req=0, Instr_valid=0, Instr=0 and PC=0.
REQ-034 SHALL abandon any outstanding request on a reset mid-operation; the instruction memory shares the same Reset.

Configuration
REQ-035 SHALL use macro FETCH_BYPASS_EN to control a same-cycle bypass.
REQ-036 SHALL, with FETCH_BYPASS_EN defined, present imem_rdata combinationally on Instr/PC with Instr_valid=1 when the queue is empty, rvalid=1 and the response is not discarded; if Instr_ready=1, the word is not pushed.
REQ-037 SHALL, without FETCH_BYPASS_EN, always register responses through the queue.

Structure
REQ-038 SHALL place the FSM state enumeration, the NOP encoding 32'h0000_0013 and the default RESET_PC in the shared cpu package.
REQ-039 SHALL implement the queue storage and pointers as sub-module fetch_fifo (DEPTH x 64 bits; push, pop, flush, full, empty, count).

Verification
REQ-040 SHALL check reset release, with grant the next cycle and rvalid 2 cycles later carrying 32'h0010_0093: imem_addr=0, and Instr_valid=1 with PC=0 one cycle after rvalid.
REQ-041 SHALL check backpressure: with Instr_ready=0 and DEPTH=4, exactly 4 pushes occur, then imem_req stays 0; releasing ready pops PC=0,4,8,C in order.
REQ-042 SHALL check a redirect in WAIT with Target=32'h0000_0102: the in-flight response is dropped, the next imem_addr is 32'h0000_0100, and the first popped PC is 32'h0000_0100.
REQ-043 SHALL check Redirect and rvalid in the same cycle: the response is discarded, the queue is empty the next cycle, and Instr_valid=0.
REQ-044 SHALL check Reset asserted in WAIT with 2 entries queued: the next cycle Instr_valid=0, state is IDLE, and the following request address is RESET_PC.
REQ-045 SHALL check, with FETCH_BYPASS_EN, an empty queue with rvalid=1 and Instr_ready=1: Instr equals imem_rdata in the same cycle and occupancy stays 0.
